tlb_lookup_unit: RTL and testbench

- Responder for the MMU's mapped-segment path: when the address-map stage flags an access as TLB-mapped (kuseg, kseg2, kseg3), this block performs the joint-TLB lookup.
- Returns the physical address, the cacheability attribute and the exception flags one cycle later.
- Also executes the CP0 TLB instructions (TLBWI, TLBWR, TLBP, TLBR) and maintains the Random register.
- Sits in the MEM-stage MMU beside the address-map logic.
- Pages are fixed at 4 KB; no PageMask support.

---
 rtl/tlb_lookup_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_tlb_lookup_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_lookup_unit.sv
// Joint TLB for the mapped-segment path of the MEM-stage MMU.
// Performs one-cycle registered lookups, executes TLBWI/TLBWR/TLBP/TLBR,
// and maintains the Random/Wired pair. Pages are fixed at 4 KB.
module tlb_lookup_unit #(
  parameter int unsigned NUM_ENTRIES = 16,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [31:0]      req_vaddr,
  input  logic             req_store,
  input  logic [7:0]       cur_asid,
  output logic             resp_valid,
  output logic [31:0]      resp_paddr,
  output logic             resp_uncached,
  output logic             resp_miss,
  output logic             resp_invalid,
  output logic             resp_modified,
  input  logic             tlbwi,
  input  logic             tlbwr,
  input  logic             tlbp,
  input  logic             tlbr,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [31:0]      cp0_entryhi,
  input  logic [31:0]      cp0_entrylo0,
  input  logic [31:0]      cp0_entrylo1,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] wired_val,
  output logic [IDX_W-1:0] random_o,
  output logic             probe_done,
  output logic [31:0]      probe_result,
  output logic             read_done,
  output logic [31:0]      read_entryhi,
  output logic [31:0]      read_entrylo0,
  output logic [31:0]      read_entrylo1
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_ENTRIES - 1);

  // Entry storage
  logic        r_present [NUM_ENTRIES];
  logic [18:0] r_vpn2    [NUM_ENTRIES];
  logic [7:0]  r_asid    [NUM_ENTRIES];
  logic        r_g       [NUM_ENTRIES];
  logic [19:0] r_pfn0    [NUM_ENTRIES];
  logic [19:0] r_pfn1    [NUM_ENTRIES];
  logic [2:0]  r_c0      [NUM_ENTRIES];
  logic [2:0]  r_c1      [NUM_ENTRIES];
  logic        r_d0      [NUM_ENTRIES];
  logic        r_d1      [NUM_ENTRIES];
  logic        r_v0      [NUM_ENTRIES];
  logic        r_v1      [NUM_ENTRIES];

  logic [IDX_W-1:0] r_random;
  logic [IDX_W-1:0] r_wired;

  logic        r_resp_valid;
  logic [31:0] r_resp_paddr;
  logic        r_resp_uncached;
  logic        r_resp_miss;
  logic        r_resp_invalid;
  logic        r_resp_modified;
  logic        r_probe_done;
  logic [31:0] r_probe_result;
  logic        r_read_done;
  logic [31:0] r_read_entryhi;
  logic [31:0] r_read_entrylo0;
  logic [31:0] r_read_entrylo1;

  // Strobe decode: write beats probe, probe beats read
  logic             w_we;
  logic [IDX_W-1:0] w_widx;
  logic             w_do_probe;
  logic             w_do_read;

  assign w_we       = tlbwi | tlbwr;
  assign w_widx     = tlbwi ? cp0_index : r_random;
  assign w_do_probe = tlbp & ~w_we;
  assign w_do_read  = tlbr & ~w_we & ~tlbp;

  // CP0 fields this block ignores (EntryHi[12:8], EntryLo[31:26])
  logic w_unused;
  assign w_unused = ^{cp0_entryhi[12:8], cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  // Lookup match: descending scan so the lowest matching index wins
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_lk_idx;
  always_comb begin
    w_lk_hit = 1'b0;
    w_lk_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_present[i] && (r_vpn2[i] == req_vaddr[31:13]) &&
          (r_g[i] || (r_asid[i] == cur_asid))) begin
        w_lk_hit = 1'b1;
        w_lk_idx = IDX_W'(i);
      end
    end
  end

  // Probe match against EntryHi, same lowest-index rule
  logic             w_pr_hit;
  logic [IDX_W-1:0] w_pr_idx;
  always_comb begin
    w_pr_hit = 1'b0;
    w_pr_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (r_present[i] && (r_vpn2[i] == cp0_entryhi[31:13]) &&
          (r_g[i] || (r_asid[i] == cp0_entryhi[7:0]))) begin
        w_pr_hit = 1'b1;
        w_pr_idx = IDX_W'(i);
      end
    end
  end

  // Page select and flag resolution (miss > invalid > modified)
  logic [19:0] w_pg_pfn;
  logic [2:0]  w_pg_c;
  logic        w_pg_d;
  logic        w_pg_v;
  logic        w_lk_miss;
  logic        w_lk_inv;
  logic        w_lk_mod;
  logic        w_lk_ok;
  always_comb begin
    w_pg_pfn  = req_vaddr[12] ? r_pfn1[w_lk_idx] : r_pfn0[w_lk_idx];
    w_pg_c    = req_vaddr[12] ? r_c1[w_lk_idx]   : r_c0[w_lk_idx];
    w_pg_d    = req_vaddr[12] ? r_d1[w_lk_idx]   : r_d0[w_lk_idx];
    w_pg_v    = req_vaddr[12] ? r_v1[w_lk_idx]   : r_v0[w_lk_idx];
    w_lk_miss = ~w_lk_hit;
    w_lk_inv  = w_lk_hit & ~w_pg_v;
    w_lk_mod  = w_lk_hit & w_pg_v & req_store & ~w_pg_d;
    w_lk_ok   = w_lk_hit & w_pg_v & ~(req_store & ~w_pg_d);
  end

  // TLBR data reconstructed in CP0 format; absent entries read as zero
  logic        w_rd_present;
  logic [31:0] w_rd_hi;
  logic [31:0] w_rd_lo0;
  logic [31:0] w_rd_lo1;
  always_comb begin
    w_rd_present = r_present[cp0_index];
    w_rd_hi      = '0;
    w_rd_lo0     = '0;
    w_rd_lo1     = '0;
    if (w_rd_present) begin
      w_rd_hi  = {r_vpn2[cp0_index], 5'b0, r_asid[cp0_index]};
      w_rd_lo0 = {6'b0, r_pfn0[cp0_index], r_c0[cp0_index], r_d0[cp0_index],
                  r_v0[cp0_index], r_g[cp0_index]};
      w_rd_lo1 = {6'b0, r_pfn1[cp0_index], r_c1[cp0_index], r_d1[cp0_index],
                  r_v1[cp0_index], r_g[cp0_index]};
    end
  end

  // Entry array update; reset only clears present bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_present[i] <= 1'b0;
      end
    end else if (w_we) begin
      r_present[w_widx] <= 1'b1;
      r_vpn2[w_widx]    <= cp0_entryhi[31:13];
      r_asid[w_widx]    <= cp0_entryhi[7:0];
      r_g[w_widx]       <= cp0_entrylo0[0] & cp0_entrylo1[0];
      r_pfn0[w_widx]    <= cp0_entrylo0[25:6];
      r_c0[w_widx]      <= cp0_entrylo0[5:3];
      r_d0[w_widx]      <= cp0_entrylo0[2];
      r_v0[w_widx]      <= cp0_entrylo0[1];
      r_pfn1[w_widx]    <= cp0_entrylo1[25:6];
      r_c1[w_widx]      <= cp0_entrylo1[5:3];
      r_d1[w_widx]      <= cp0_entrylo1[2];
      r_v1[w_widx]      <= cp0_entrylo1[1];
    end
  end

  // Random counts down toward Wired, then wraps to the top entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_random <= LastIdx;
      r_wired  <= '0;
    end else if (wired_we) begin
      r_wired  <= wired_val;
      r_random <= LastIdx;
    end else if ((r_wired >= LastIdx) || (r_random <= r_wired)) begin
      r_random <= LastIdx;
    end else begin
      r_random <= r_random - IDX_W'(1);
    end
  end

  // Registered lookup, probe and read responses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_resp_valid    <= 1'b0;
      r_resp_paddr    <= '0;
      r_resp_uncached <= 1'b0;
      r_resp_miss     <= 1'b0;
      r_resp_invalid  <= 1'b0;
      r_resp_modified <= 1'b0;
      r_probe_done    <= 1'b0;
      r_probe_result  <= '0;
      r_read_done     <= 1'b0;
      r_read_entryhi  <= '0;
      r_read_entrylo0 <= '0;
      r_read_entrylo1 <= '0;
    end else begin
      r_resp_valid    <= req_valid;
      r_resp_miss     <= req_valid & w_lk_miss;
      r_resp_invalid  <= req_valid & w_lk_inv;
      r_resp_modified <= req_valid & w_lk_mod;
      r_resp_uncached <= req_valid & w_lk_ok & (w_pg_c == 3'd2);
      r_resp_paddr    <= (req_valid && w_lk_ok) ? {w_pg_pfn, req_vaddr[11:0]} : 32'h0;
      r_probe_done    <= w_do_probe;
      if (w_do_probe) begin
        r_probe_result <= w_pr_hit ? {{(32 - IDX_W){1'b0}}, w_pr_idx} : 32'h8000_0000;
      end
      r_read_done <= w_do_read;
      if (w_do_read) begin
        r_read_entryhi  <= w_rd_hi;
        r_read_entrylo0 <= w_rd_lo0;
        r_read_entrylo1 <= w_rd_lo1;
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_paddr    = r_resp_paddr;
  assign resp_uncached = r_resp_uncached;
  assign resp_miss     = r_resp_miss;
  assign resp_invalid  = r_resp_invalid;
  assign resp_modified = r_resp_modified;
  assign random_o      = r_random;
  assign probe_done    = r_probe_done;
  assign probe_result  = r_probe_result;
  assign read_done     = r_read_done;
  assign read_entryhi  = r_read_entryhi;
  assign read_entrylo0 = r_read_entrylo0;
  assign read_entrylo1 = r_read_entrylo1;

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Scoreboard bench for tlb_lookup_unit: stimulus pushes expected responses,
// a negedge monitor pops and compares whenever a done/valid strobe appears.
module tb_tlb_lookup_unit;

  localparam int unsigned NE = 16;
  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic [31:0]   req_vaddr;
  logic          req_store;
  logic [7:0]    cur_asid;
  logic          resp_valid;
  logic [31:0]   resp_paddr;
  logic          resp_uncached;
  logic          resp_miss;
  logic          resp_invalid;
  logic          resp_modified;
  logic          tlbwi;
  logic          tlbwr;
  logic          tlbp;
  logic          tlbr;
  logic [IW-1:0] cp0_index;
  logic [31:0]   cp0_entryhi;
  logic [31:0]   cp0_entrylo0;
  logic [31:0]   cp0_entrylo1;
  logic          wired_we;
  logic [IW-1:0] wired_val;
  logic [IW-1:0] random_o;
  logic          probe_done;
  logic [31:0]   probe_result;
  logic          read_done;
  logic [31:0]   read_entryhi;
  logic [31:0]   read_entrylo0;
  logic [31:0]   read_entrylo1;

  tlb_lookup_unit #(.NUM_ENTRIES(NE), .IDX_W(IW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_vaddr     (req_vaddr),
    .req_store     (req_store),
    .cur_asid      (cur_asid),
    .resp_valid    (resp_valid),
    .resp_paddr    (resp_paddr),
    .resp_uncached (resp_uncached),
    .resp_miss     (resp_miss),
    .resp_invalid  (resp_invalid),
    .resp_modified (resp_modified),
    .tlbwi         (tlbwi),
    .tlbwr         (tlbwr),
    .tlbp          (tlbp),
    .tlbr          (tlbr),
    .cp0_index     (cp0_index),
    .cp0_entryhi   (cp0_entryhi),
    .cp0_entrylo0  (cp0_entrylo0),
    .cp0_entrylo1  (cp0_entrylo1),
    .wired_we      (wired_we),
    .wired_val     (wired_val),
    .random_o      (random_o),
    .probe_done    (probe_done),
    .probe_result  (probe_result),
    .read_done     (read_done),
    .read_entryhi  (read_entryhi),
    .read_entrylo0 (read_entrylo0),
    .read_entrylo1 (read_entrylo1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        miss;
    logic        inv;
    logic        md;
    logic        unc;
    logic [31:0] pa;
  } lk_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo0;
    logic [31:0] lo1;
  } rd_t;

  lk_t         lk_q[$];
  logic [31:0] pr_q[$];
  rd_t         rd_q[$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: compare every presented response against the scoreboard
  always @(negedge clk) begin : monitor
    lk_t e_lk;
    rd_t e_rd;
    if (resp_valid) begin
      if (lk_q.size() == 0) begin
        chk("lk_spurious", {31'b0, resp_valid}, 32'd0);
      end else begin
        e_lk = lk_q.pop_front();
        chk("lk_flags", {28'b0, resp_miss, resp_invalid, resp_modified, resp_uncached},
            {28'b0, e_lk.miss, e_lk.inv, e_lk.md, e_lk.unc});
        chk("lk_paddr", resp_paddr, e_lk.pa);
      end
    end
    if (probe_done) begin
      if (pr_q.size() == 0) chk("pr_spurious", {31'b0, probe_done}, 32'd0);
      else chk("probe_result", probe_result, pr_q.pop_front());
    end
    if (read_done) begin
      if (rd_q.size() == 0) begin
        chk("rd_spurious", {31'b0, read_done}, 32'd0);
      end else begin
        e_rd = rd_q.pop_front();
        chk("rd_hi", read_entryhi, e_rd.hi);
        chk("rd_lo0", read_entrylo0, e_rd.lo0);
        chk("rd_lo1", read_entrylo1, e_rd.lo1);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    req_valid = 1'b0;
    req_store = 1'b0;
    tlbwi     = 1'b0;
    tlbwr     = 1'b0;
    tlbp      = 1'b0;
    tlbr      = 1'b0;
    wired_we  = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] va, input logic st, input logic m, input logic inv,
                        input logic md, input logic unc, input logic [31:0] pa);
    req_valid = 1'b1;
    req_vaddr = va;
    req_store = st;
    lk_q.push_back({m, inv, md, unc, pa});
  endtask

  task automatic write(input logic [IW-1:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1);
    tlbwi        = 1'b1;
    cp0_index    = idx;
    cp0_entryhi  = hi;
    cp0_entrylo0 = lo0;
    cp0_entrylo1 = lo1;
  endtask

  task automatic probe(input logic [31:0] hi, input logic [31:0] exp);
    tlbp        = 1'b1;
    cp0_entryhi = hi;
    pr_q.push_back(exp);
  endtask

  task automatic read(input logic [IW-1:0] idx, input logic [31:0] hi,
                      input logic [31:0] lo0, input logic [31:0] lo1);
    tlbr      = 1'b1;
    cp0_index = idx;
    rd_q.push_back({hi, lo0, lo1});
  endtask

  logic [IW-1:0] exp_rnd;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0; cur_asid = 8'd5;
    tlbwi = 1'b0; tlbwr = 1'b0; tlbp = 1'b0; tlbr = 1'b0; cp0_index = '0;
    cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0; wired_we = 1'b0; wired_val = '0;
    step(); step();
    chk("reset_random", {28'b0, random_o}, 32'd15);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_probe_done", {31'b0, probe_done}, 32'd0);
    rst_n = 1'b1;

    // Empty TLB: miss
    lookup(32'h0040_1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    // TLBWI idx 3 with a same-cycle lookup (old contents) and a dropped probe
    write(4'd3, 32'h0040_0005, 32'h0000_48DE, 32'h0001_1592);
    lookup(32'h0040_0ABC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tlbp = 1'b1;
    step();
    // Back-to-back lookups: even page cached, odd page uncached
    lookup(32'h0040_0ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0012_3ABC); step();
    lookup(32'h0040_1ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0045_6ABC); step();
    lookup(32'h0040_1000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0); step();
    lookup(32'h0040_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0012_3000); step();
    cur_asid = 8'd6;
    lookup(32'h0040_0ABC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    cur_asid = 8'd5;
    // Invalid even page with D=0: invalid outranks modified on a store
    write(4'd5, 32'h0040_2005, 32'h0001_DDD8, 32'h0); step();
    lookup(32'h0040_2010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0); step();
    // Probe hit / miss, read back present and absent entries
    probe(32'h0040_0005, 32'h0000_0003); step();
    probe(32'h0080_0005, 32'h8000_0000); step();
    read(4'd3, 32'h0040_0005, 32'h0000_48DE, 32'h0001_1592); step();
    read(4'd7, 32'h0, 32'h0, 32'h0); step();
    // Global rewrite of idx 3, duplicate VPN at idx 10: lowest index wins
    write(4'd3, 32'h0040_0005, 32'h0000_48DF, 32'h0001_1593); step();
    write(4'd10, 32'h0040_0005, 32'h0002_EEDE, 32'h0); step();
    cur_asid = 8'd6;
    lookup(32'h0040_0ABC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0012_3ABC);
    probe(32'h0040_0005, 32'h0000_0003);
    step();
    cur_asid = 8'd5;
    // G needs both lo G bits; only lo0 G set -> stored G = 0
    write(4'd6, 32'h0060_0007, 32'h0000_0001, 32'h0); step();
    read(4'd6, 32'h0060_0007, 32'h0, 32'h0); step();

    // Wired = 4: Random runs 15..4 then wraps; TLBWR at Random = 9
    wired_we = 1'b1; wired_val = 4'd4;
    exp_rnd = 4'd15;
    for (int k = 0; k < 14; k++) begin
      step();
      chk("random_seq", {28'b0, random_o}, {28'b0, exp_rnd});
      if (exp_rnd == 4'd9) begin
        tlbwr        = 1'b1;
        cp0_index    = 4'd0;
        cp0_entryhi  = 32'h00C0_0005;
        cp0_entrylo0 = 32'h0002_665E;
        cp0_entrylo1 = 32'h0;
      end
      exp_rnd = (exp_rnd == 4'd4) ? 4'd15 : exp_rnd - 4'd1;
    end
    read(4'd9, 32'h00C0_0005, 32'h0002_665E, 32'h0); step();
    lookup(32'h00C0_0123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0099_9123); step();
    // TLBWI and TLBWR together: TLBWI index wins
    write(4'd12, 32'h0100_0005, 32'h0000_48DE, 32'h0);
    tlbwr = 1'b1;
    step();
    read(4'd12, 32'h0100_0005, 32'h0000_48DE, 32'h0); step();

    // Reset on the request's sampling edge: no response, entries cleared
    req_valid = 1'b1; req_vaddr = 32'h0040_0ABC; rst_n = 1'b0;
    step();
    chk("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_random", {28'b0, random_o}, 32'd15);
    rst_n = 1'b1;
    lookup(32'h0040_0ABC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0); step();
    step(); step();

    chk("lk_q_left", 32'(lk_q.size()), 32'd0);
    chk("pr_q_left", 32'(pr_q.size()), 32'd0);
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
